// File: rtl/parity_pkg.sv
// Shared constants for the serial parity link.
// Used by both the transmit serializer and the receive checker.
package parity_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/parity_serializer.sv
// Transmit end of the serial parity link: word in over valid/ready,
// bits out LSB first followed by one parity bit.
module parity_serializer #(
  parameter int DATA_W     = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_bit,
  output logic              out_valid,
  output logic              out_sof,
  output logic              out_last,
  output logic              busy
);
  import parity_pkg::*;

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DATA_W - 1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;
  logic              par;
  logic              accept;
  logic              last_bit;
  logic              bit_nxt;
  logic              valid_nxt;
  logic              sof_nxt;
  logic              last_nxt;

  assign in_ready = reset_n & (state != ST_DATA);
  assign accept   = in_valid & in_ready;
  assign last_bit = (cnt == CNT_LAST);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      cnt       <= '0;
      par       <= 1'b0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_bit   <= bit_nxt;
      out_valid <= valid_nxt;
      out_sof   <= sof_nxt;
      out_last  <= last_nxt;
      if (accept) begin
        shreg <= in_data;
        par   <= ^in_data ^ PARITY_ODD;
        cnt   <= '0;
      end else if (state == ST_DATA && !last_bit) begin
        shreg <= shreg >> 1;
        cnt   <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == ST_IDLE):
        if (accept) state_nxt = ST_DATA;
      (state == ST_DATA):
        if (last_bit) state_nxt = ST_PARITY;
      (state == ST_PARITY):
        state_nxt = accept ? ST_DATA : ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  // out_bit already shows shreg[0]; the next bit is shreg[1]
  always_comb begin
    bit_nxt   = 1'b0;
    valid_nxt = 1'b0;
    sof_nxt   = 1'b0;
    last_nxt  = 1'b0;
    if (accept) begin
      bit_nxt   = in_data[0];
      valid_nxt = 1'b1;
      sof_nxt   = 1'b1;
    end else if (state == ST_DATA) begin
      valid_nxt = 1'b1;
      if (last_bit) begin
        bit_nxt  = par;
        last_nxt = 1'b1;
      end else begin
        bit_nxt = shreg[1];
      end
    end
  end

endmodule

// File: tb/tb_parity_serializer.sv
// Scoreboard bench: even and odd instances share stimulus;
// expected serial streams are built from the word at accept time.
module tb_parity_serializer;

  localparam int W = 8;

  typedef struct {
    logic b_even;
    logic b_odd;
    logic sof;
    logic last;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         rdy [2];
  logic         ob  [2];
  logic         ov  [2];
  logic         os  [2];
  logic         ol  [2];
  logic         bz  [2];

  exp_t q[$];
  int   vecs = 0;
  int   errs = 0;
  logic trk [2];

  always #5 clk = ~clk;

  parity_serializer #(.DATA_W(W), .PARITY_ODD(1'b0)) dut_even (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[0]), .out_bit(ob[0]),
    .out_valid(ov[0]), .out_sof(os[0]),
    .out_last(ol[0]), .busy(bz[0])
  );

  parity_serializer #(.DATA_W(W), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[1]), .out_bit(ob[1]),
    .out_valid(ov[1]), .out_sof(os[1]),
    .out_last(ol[1]), .busy(bz[1])
  );

  task automatic cmp(input string nm, input logic [15:0] act,
                     input logic [15:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h at %0t",
               nm, act, req, $time);
    end
  endtask

  // Reference stream: data bits LSB first, then parity from the ones count
  task automatic push_word(input logic [W-1:0] w);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      e.b_even = w[i];
      e.b_odd  = w[i];
      e.sof    = (i == 0);
      e.last   = 1'b0;
      q.push_back(e);
    end
    e.b_even = ($countones(w) % 2 == 1);
    e.b_odd  = ($countones(w) % 2 == 0);
    e.sof    = 1'b0;
    e.last   = 1'b1;
    q.push_back(e);
  endtask

  task automatic send(input logic [W-1:0] w);
    int t;
    @(negedge clk);
    in_data  = w;
    in_valid = 1'b1;
    #1;
    t = 0;
    while (!rdy[0] && t < 64) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!rdy[0]) begin
      errs++;
      vecs++;
      $display("FAIL send_timeout: in_ready 0, expected 1 for %0h", w);
    end else begin
      push_word(w);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_wait();
    int t;
    t = 0;
    @(negedge clk);
    while (bz[0] && t < 64) begin
      @(negedge clk);
      t++;
    end
    cmp("idle_timeout_busy", 16'(bz[0]), 16'h0);
  endtask

  task automatic check_quiet(input string nm);
    for (int k = 0; k < 2; k++) begin
      cmp({nm, "_ready"}, 16'(rdy[k]), 16'h0);
      cmp({nm, "_outs"}, {12'h0, ob[k], ov[k], os[k], ol[k]}, 16'h0);
      cmp({nm, "_busy"}, 16'(bz[k]), 16'h0);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b1 && (ov[0] || ov[1])) begin
      if (q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_output: out_valid 1, expected 0");
      end else begin
        e = q.pop_front();
        cmp("valid_even", 16'(ov[0]), 16'h1);
        cmp("valid_odd", 16'(ov[1]), 16'h1);
        cmp("bit_even", 16'(ob[0]), 16'(e.b_even));
        cmp("bit_odd", 16'(ob[1]), 16'(e.b_odd));
        cmp("sof", {14'h0, os[0], os[1]}, {14'h0, e.sof, e.sof});
        cmp("last", {14'h0, ol[0], ol[1]}, {14'h0, e.last, e.last});
        cmp("busy", {14'h0, bz[0], bz[1]}, 16'h3);
      end
    end
  end

  // Downstream running-parity tracker fed by the serial stream
  always @(negedge clk) begin
    logic t;
    if (reset_n === 1'b1) begin
      for (int k = 0; k < 2; k++) begin
        if (ov[k]) begin
          t = os[k] ? ob[k] : (trk[k] ^ ob[k]);
          trk[k] = t;
          if (ol[k])
            cmp(k == 0 ? "tracker_even" : "tracker_odd",
                16'(t), 16'(k));
        end
      end
    end
  end

  initial begin
    int cnt;
    logic v_seen [19];
    logic s_seen [19];

    // 1: reset held with in_valid high
    in_valid = 1'b1;
    in_data  = 8'h5A;
    reset_n  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_quiet("reset");
    end
    in_valid = 1'b0;
    reset_n  = 1'b1;

    // 2: 0xA5, first bit one cycle after accept
    send(8'hA5);
    in_valid = 1'b0;
    @(negedge clk);
    cmp("latency_valid_sof", {14'h0, ov[0], os[0]}, 16'h3);
    idle_wait();

    // 3: 0x07 in both parity modes
    send(8'h07);
    in_valid = 1'b0;
    idle_wait();

    // 4: back-to-back 0x01 then 0x03
    send(8'h01);
    fork
      begin
        send(8'h03);
        in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 19; i++) begin
          @(negedge clk);
          v_seen[i] = ov[0];
          s_seen[i] = os[0];
        end
      end
    join
    for (int i = 0; i < 19; i++) begin
      cmp("b2b_valid", 16'(v_seen[i]), 16'(i < 18));
      cmp("b2b_sof", 16'(s_seen[i]), 16'(i == 0 || i == 9));
    end
    idle_wait();

    // 5: reset after three data bits of 0xFF
    send(8'hFF);
    in_valid = 1'b0;
    cnt = 0;
    for (int t = 0; t < 32 && cnt < 3; t++) begin
      @(negedge clk);
      if (ov[0]) cnt++;
    end
    cmp("midframe_bits_seen", 16'(cnt), 16'd3);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    @(negedge clk);
    check_quiet("midframe_reset");
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    cmp("after_reset_valid", 16'(ov[0]), 16'h0);
    send(8'h80);
    in_valid = 1'b0;
    idle_wait();

    // 6: random words with random gaps
    for (int n = 0; n < 256; n++) begin
      send(W'($urandom));
      if ($urandom_range(0, 2) != 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 12)) @(negedge clk);
      end
    end
    in_valid = 1'b0;

    cnt = 0;
    while ((q.size() != 0 || bz[0]) && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    cmp("queue_drained", 16'(q.size()), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
